// File: rtl/uart_tx_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_arb                                                   |
// | Purpose  : Round-robin, packet-locking arbiter sharing one uart_tx       |
// |            among NREQ byte-stream requesters.                            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_tx_arb #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_end,
  output logic [2:0]        owner,
  output logic              locked
);

  localparam int C_IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int C_HW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [C_IW-1:0] owner_q, owner_d;
  logic [C_IW-1:0] rr_q, rr_d;
  logic [C_HW-1:0] hold_q, hold_d;
  logic            locked_q, locked_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [C_IW-1:0] winner;
  logic [C_IW-1:0] owner_inc;

  // Descending scan so the requester closest to the pointer is assigned last and wins.
  function automatic logic [C_IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [C_IW-1:0] p);
    int j;
    rr_pick = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= NREQ) j = j - NREQ;
      if (r[j]) rr_pick = C_IW'(j);
    end
  endfunction

  assign winner    = rr_pick(req, rr_q);
  assign owner_inc = (owner_q == C_IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ARB;
      owner_q    <= '0;
      rr_q       <= '0;
      hold_q     <= '0;
      locked_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      locked_q   <= locked_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    hold_d     = hold_q;
    locked_d   = locked_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    ack_d      = '0;
    case (state_q)
      ARB: begin
        if (!locked_q && (|req) && !tx_busy) begin
          owner_d = winner;
          state_d = SEND;
        end
      end
      SEND: begin
        // A request withdrawn after the grant is dropped instead of being sent.
        if (req[owner_q]) begin
          tx_start_d     = 1'b1;
          tx_data_d      = req_data[{owner_q, 3'b000} +: 8];
          ack_d[owner_q] = 1'b1;
          locked_d       = ~req_last[owner_q];
          state_d        = WAIT;
        end else if (locked_q) begin
          hold_d  = '0;
          state_d = HOLD;
        end else begin
          state_d = ARB;
        end
      end
      WAIT: begin
        if (tx_end) begin
          if (locked_q && req[owner_q]) begin
            state_d = SEND;
          end else if (locked_q) begin
            hold_d  = '0;
            state_d = HOLD;
          end else begin
            rr_d    = owner_inc;
            state_d = ARB;
          end
        end
      end
      HOLD: begin
        if (req[owner_q]) begin
          state_d = SEND;
        end else if (hold_q == C_HW'(HOLD_MAX)) begin
          locked_d = 1'b0;
          rr_d     = owner_inc;
          state_d  = ARB;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign owner    = 3'(owner_q);
  assign locked   = locked_q;

endmodule
`default_nettype wire
